// File: rtl/bit_count_pkg.sv
// bit_count_pkg: mode and state encodings shared by the bit counter
package bit_count_pkg;
   localparam logic [1:0] MODE_ONES  = 2'b00;
   localparam logic [1:0] MODE_ZEROS = 2'b01;
   localparam logic [1:0] MODE_LZ    = 2'b10;
   localparam logic [1:0] MODE_TZ    = 2'b11;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bit_count_chunk.sv
// bit_count_chunk: per-chunk popcount or zero-prefix length with first-one flag
module bit_count_chunk import bit_count_pkg::*; #(
   parameter int STEP = 1
) (
   input  logic [STEP-1:0]            chunk,
   input  logic [1:0]                 mode,
   output logic [$clog2(STEP+1)-1:0]  cnt,
   output logic                       hit
);
   localparam int CCW = $clog2(STEP+1);
   logic b;
   always_comb begin
      cnt = '0;
      hit = 1'b0;
      b = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         b = (mode == MODE_LZ) ? chunk[STEP-1-i] : chunk[i];
         if (!mode[1]) cnt = cnt + CCW'(chunk[i] ^ (mode == MODE_ZEROS));
         else if (!hit && b) hit = 1'b1;
         else if (!hit) cnt = cnt + CCW'(1);
      end
   end
endmodule

// File: rtl/bit_count_seq.sv
// bit_count_seq: handshaked sequential ones/zeros/leading/trailing-zero counter
module bit_count_seq import bit_count_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           data_in,
   input  logic [1:0]                 mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] count,
   output logic                       busy
);
   localparam int N   = WIDTH / STEP;
   localparam int CW  = $clog2(WIDTH+1);
   localparam int IW  = $clog2(N+1);
   localparam int CCW = $clog2(STEP+1);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q;
   logic [1:0]       md_q;
   logic [IW-1:0]    idx_q;
   logic [STEP-1:0]  chunk;
   logic [CCW-1:0]   ccnt;
   logic             hit, last, acc;
   assign chunk = (md_q == MODE_LZ) ? sr_q[WIDTH-1 -: STEP] : sr_q[STEP-1:0];
   assign acc   = in_valid && in_ready;
   assign last  = (idx_q == IW'(N-1)) || (md_q[1] && hit);
   bit_count_chunk #(.STEP(STEP)) u_chunk (
      .chunk(chunk),
      .mode (md_q),
      .cnt  (ccnt),
      .hit  (hit)
   );
   always_comb begin
      state_d = (state_q == IDLE && acc)       ? RUN  :
                (state_q == RUN  && last)      ? DONE :
                (state_q == DONE && out_ready) ? IDLE : state_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   // status flags are registered from the next state so they track state_q exactly
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q      <= '0;
         md_q      <= '0;
         idx_q     <= '0;
         count     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= state_d == IDLE;
         out_valid <= state_d == DONE;
         busy      <= state_d == RUN;
         if (state_q == IDLE && acc) begin
            sr_q  <= data_in;
            md_q  <= mode;
            idx_q <= '0;
            count <= '0;
         end else if (state_q == RUN) begin
            sr_q  <= (md_q == MODE_LZ) ? sr_q << STEP : sr_q >> STEP;
            idx_q <= idx_q + IW'(1);
            count <= count + CW'(ccnt);
         end
      end
   end
endmodule

// File: tb/tb_bit_count_seq.sv
// tb_bit_count_seq: table-driven check of two bit_count_seq instances (STEP=1 and STEP=4)
module tb_bit_count_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] data_in = '0;
   logic [1:0] mode = '0;
   logic out_ready = 1'b0;
   logic iv1 = 1'b0, iv4 = 1'b0;
   logic ir1, ir4, ov1, ov4, bz1, bz4;
   logic [4:0] cnt1, cnt4;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bit_count_seq #(.WIDTH(16), .STEP(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .data_in(data_in),
      .mode(mode), .out_valid(ov1), .out_ready(out_ready), .count(cnt1), .busy(bz1));
   bit_count_seq #(.WIDTH(16), .STEP(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .data_in(data_in),
      .mode(mode), .out_valid(ov4), .out_ready(out_ready), .count(cnt4), .busy(bz4));

   typedef struct {
      int          s;
      logic [15:0] d;
      logic [1:0]  m;
      int          c;
      int          k;
      string       nm;
   } vec_t;

   function automatic logic g_ir(int s); return s == 1 ? ir1 : ir4; endfunction
   function automatic logic g_ov(int s); return s == 1 ? ov1 : ov4; endfunction
   function automatic logic g_bz(int s); return s == 1 ? bz1 : bz4; endfunction
   function automatic int   g_ct(int s); return s == 1 ? int'(cnt1) : int'(cnt4); endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic start(input int s, input logic [15:0] d, input logic [1:0] m, input string nm);
      int w = 0;
      while (!g_ir(s) && w < 40) begin @(negedge clk); w++; end
      chk({nm, "_ready"}, int'(g_ir(s)), 1);
      data_in = d;
      mode = m;
      if (s == 1) iv1 = 1'b1; else iv4 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      iv4 = 1'b0;
      data_in = ~d;
      mode = ~m;
   endtask

   task automatic wait_done(input int s, output int k, output int b);
      k = 0;
      b = 0;
      while (!g_ov(s) && k < 40) begin
         b += int'(g_bz(s));
         @(negedge clk);
         k++;
      end
   endtask

   task automatic xfer(input vec_t v);
      int k, b;
      start(v.s, v.d, v.m, v.nm);
      wait_done(v.s, k, b);
      chk({v.nm, "_count"}, g_ct(v.s), v.c);
      chk({v.nm, "_latency"}, k, v.k);
      chk({v.nm, "_busy"}, b, v.k);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.nm, "_ovdrop"}, int'(g_ov(v.s)), 0);
      chk({v.nm, "_irrise"}, int'(g_ir(v.s)), 1);
   endtask

   vec_t tbl[13];

   initial begin
      int k, b;
      tbl[0]  = '{1, 16'hFFFF, 2'b00, 16, 16, "ones_ffff"};
      tbl[1]  = '{1, 16'hA5A5, 2'b01,  8, 16, "zeros_a5a5_s1"};
      tbl[2]  = '{4, 16'hA5A5, 2'b01,  8,  4, "zeros_a5a5_s4"};
      tbl[3]  = '{4, 16'h00F0, 2'b10,  8,  3, "lz_00f0"};
      tbl[4]  = '{4, 16'h0000, 2'b10, 16,  4, "lz_0000"};
      tbl[5]  = '{1, 16'h0008, 2'b11,  3,  4, "tz_0008"};
      tbl[6]  = '{1, 16'h8000, 2'b11, 15, 16, "tz_8000"};
      tbl[7]  = '{4, 16'h1234, 2'b00,  5,  4, "ones_1234"};
      tbl[8]  = '{4, 16'h0100, 2'b11,  8,  3, "tz_0100"};
      tbl[9]  = '{1, 16'h0001, 2'b10, 15, 16, "lz_0001"};
      tbl[10] = '{1, 16'h8000, 2'b10,  0,  1, "lz_8000"};
      tbl[11] = '{4, 16'h0300, 2'b10,  6,  2, "lz_0300"};
      tbl[12] = '{4, 16'h0060, 2'b11,  5,  2, "tz_0060"};

      @(negedge clk);
      chk("rst_ir1", int'(ir1), 0);
      chk("rst_ov1", int'(ov1), 0);
      chk("rst_bz1", int'(bz1), 0);
      chk("rst_cnt1", int'(cnt1), 0);
      chk("rst_ir4", int'(ir4), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ir1", int'(ir1), 1);
      chk("post_rst_ir4", int'(ir4), 1);

      for (int i = 0; i < 13; i++) xfer(tbl[i]);

      start(1, 16'h000F, 2'b00, "bp");
      wait_done(1, k, b);
      chk("bp_latency", k, 16);
      for (int i = 0; i < 5; i++) begin
         iv1 = 1'b1;
         data_in = 16'hFFFF;
         mode = 2'b00;
         @(negedge clk);
         iv1 = 1'b0;
         chk("bp_ov", int'(ov1), 1);
         chk("bp_count", int'(cnt1), 4);
         chk("bp_ir", int'(ir1), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_ir_after", int'(ir1), 1);
      chk("bp_ov_after", int'(ov1), 0);
      @(negedge clk);
      chk("bp_no_phantom", int'(bz1), 0);

      start(1, 16'hFFFF, 2'b00, "mid_rst");
      repeat (4) @(negedge clk);
      chk("mid_rst_busy_before", int'(bz1), 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_ov", int'(ov1), 0);
      chk("mid_rst_bz", int'(bz1), 0);
      chk("mid_rst_cnt", int'(cnt1), 0);
      chk("mid_rst_ir", int'(ir1), 0);
      @(negedge clk);
      reset = 1'b1;
      xfer('{1, 16'h0001, 2'b00, 1, 16, "after_rst"});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
